// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter that shares one pipelined 8-input adder tree between NUM_REQ requesters.
// Issues are tagged, realigned with the returning sum and queued in a credit-protected FIFO.
module adder_tree_arbiter #(
    parameter int unsigned ADDER_WIDTH  = 15,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned TREE_LATENCY = 2,
    parameter int unsigned RESP_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*8*ADDER_WIDTH-1:0] req_data,
    output logic [8*ADDER_WIDTH-1:0]         tree_in,
    input  logic [ADDER_WIDTH+2:0]           tree_sum,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]       resp_id,
    output logic [ADDER_WIDTH+2:0]           resp_sum,
    output logic                             busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned SumW = ADDER_WIDTH + 3;
    localparam int unsigned SetW = 8 * ADDER_WIDTH;
    localparam int unsigned PtrW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);

    // Arbitration state
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [IdW-1:0]  winner;
    logic [IdW-1:0]  cand;
    logic            found;
    logic            issue;
    logic [SetW-1:0] win_data;
    logic [SetW-1:0] tree_in_q, tree_in_d;

    // Tag pipeline
    logic [TREE_LATENCY-1:0] tag_vld_q;
    logic [IdW-1:0]          tag_id_q [TREE_LATENCY];
    logic                    push;
    logic [IdW-1:0]          push_id;

    // Response FIFO and credits
    logic [IdW-1:0]  fifo_id_q  [RESP_DEPTH];
    logic [SumW-1:0] fifo_sum_q [RESP_DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] credits_q, credits_d;
    logic [IdW-1:0]  last_id_q, last_id_d;
    logic [SumW-1:0] last_sum_q, last_sum_d;
    logic            pop;

    // Rotating priority search starting at the pointer.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IdW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign issue    = !rst && (credits_q != '0) && found;
    assign win_data = req_data[32'(winner)*SetW +: SetW];

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = issue && (winner == IdW'(i));
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        tree_in_d = tree_in_q;
        if (issue) begin
            ptr_d     = (winner == IdW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            tree_in_d = win_data;
        end
    end

    // The tree captures tree_in at the issue edge, so drive the new set combinationally.
    assign tree_in = tree_in_d;

    assign push    = tag_vld_q[TREE_LATENCY-1];
    assign push_id = tag_id_q[TREE_LATENCY-1];

    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_id    = resp_valid ? fifo_id_q[head_q]  : last_id_q;
    assign resp_sum   = resp_valid ? fifo_sum_q[head_q] : last_sum_q;
    assign busy       = (|tag_vld_q) || resp_valid;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        credits_d  = credits_q;
        last_id_d  = last_id_q;
        last_sum_d = last_sum_q;
        if (pop) begin
            head_d     = (head_q == PtrW'(RESP_DEPTH - 1)) ? '0 : head_q + 1'b1;
            last_id_d  = fifo_id_q[head_q];
            last_sum_d = fifo_sum_q[head_q];
        end
        if (push) begin
            tail_d = (tail_q == PtrW'(RESP_DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Each credit covers one slot reserved from issue until the result is popped.
        case ({issue, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            tree_in_q  <= '0;
            tag_vld_q  <= '0;
            for (int i = 0; i < TREE_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            credits_q  <= CntW'(RESP_DEPTH);
            last_id_q  <= '0;
            last_sum_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tree_in_q    <= tree_in_d;
            tag_vld_q[0] <= issue;
            tag_id_q[0]  <= winner;
            for (int i = 1; i < TREE_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            credits_q  <= credits_d;
            last_id_q  <= last_id_d;
            last_sum_q <= last_sum_d;
        end
    end

    // Storage only; occupancy is tracked by the reset-controlled pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[tail_q]  <= push_id;
            fifo_sum_q[tail_q] <= tree_sum;
        end
    end

endmodule
